// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Bundles the pixel-side signals of the VGA timing generator.
//   master modport (generator side):
//     in : Red, Green, Blue   colour for the current DrawX/DrawY (combinational from mapper)
//     out: DrawX, DrawY       current pixel counters
//     out: pixel_en           one-Clk strobe per pixel
//     out: frame_start        pulse at pixel (0,0)
//     out: vblank_start       pulse at pixel (0,V_VISIBLE)
//     out: VGA_HS, VGA_VS     active-low syncs
//     out: VGA_BLANK_N        low outside the visible area
//     out: VGA_SYNC_N         tied low
//     out: VGA_R/G/B          registered pixel colour
//   slave modport: the colour mapper / DAC side, directions mirrored.
interface vga_timing_gen_if;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pixel_en;
    logic       frame_start;
    logic       vblank_start;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        input  Red, Green, Blue,
        output DrawX, DrawY, pixel_en, frame_start, vblank_start,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output Red, Green, Blue,
        input  DrawX, DrawY, pixel_en, frame_start, vblank_start,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generates VGA raster timing from a Clk running at twice the pixel rate.
// A phase bit divides Clk by two; hc/vc advance once per pixel strobe.
// Sync, blank and colour outputs are registered one pixel behind DrawX/DrawY.
// Ports:
//   Clk    : system clock (2x pixel clock)
//   Reset  : synchronous, active-high reset
//   vga    : vga_timing_gen_if.master (colour in, counters/strobes/VGA out)
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              Clk,
    input  logic              Reset,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       phase_r;
    logic [9:0] hc_r;
    logic [9:0] vc_r;
    logic       hs_r;
    logic       vs_r;
    logic       blank_n_r;
    logic [7:0] r_r;
    logic [7:0] g_r;
    logic [7:0] b_r;

    logic       pixel_en_s;
    logic       visible_s;
    logic       hsync_s;
    logic       vsync_s;
    logic       frame_start_s;
    logic       vblank_start_s;

    // Decode strobes and raster regions from the current counters.
    always_comb begin
        pixel_en_s     = 1'b0;
        visible_s      = 1'b0;
        hsync_s        = 1'b0;
        vsync_s        = 1'b0;
        frame_start_s  = 1'b0;
        vblank_start_s = 1'b0;
        // Gating with Reset keeps the strobes quiet during a reset that lands in phase 1.
        pixel_en_s     = phase_r & ~Reset;
        visible_s      = (hc_r < H_VIS) && (vc_r < V_VIS);
        hsync_s        = (hc_r >= HS_BEGIN) && (hc_r < HS_END);
        vsync_s        = (vc_r >= VS_BEGIN) && (vc_r < VS_END);
        frame_start_s  = pixel_en_s && (hc_r == 10'd0) && (vc_r == 10'd0);
        vblank_start_s = pixel_en_s && (hc_r == 10'd0) && (vc_r == V_VIS);
    end

    // Phase divider and horizontal/vertical raster counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_r <= 1'b0;
            hc_r    <= 10'd0;
            vc_r    <= 10'd0;
        end else begin
            phase_r <= ~phase_r;
            if (phase_r) begin
                if (hc_r == H_LAST) begin
                    hc_r <= 10'd0;
                    if (vc_r == V_LAST) begin
                        vc_r <= 10'd0;
                    end else begin
                        vc_r <= vc_r + 10'd1;
                    end
                end else begin
                    hc_r <= hc_r + 10'd1;
                end
            end else begin
                hc_r <= hc_r;
                vc_r <= vc_r;
            end
        end
    end

    // Output stage: captures the pixel being drawn, so it trails DrawX/DrawY by one pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
            r_r       <= 8'd0;
            g_r       <= 8'd0;
            b_r       <= 8'd0;
        end else if (phase_r) begin
            hs_r      <= ~hsync_s;
            vs_r      <= ~vsync_s;
            blank_n_r <= visible_s;
            r_r       <= visible_s ? vga.Red   : 8'd0;
            g_r       <= visible_s ? vga.Green : 8'd0;
            b_r       <= visible_s ? vga.Blue  : 8'd0;
        end else begin
            hs_r      <= hs_r;
            vs_r      <= vs_r;
            blank_n_r <= blank_n_r;
            r_r       <= r_r;
            g_r       <= g_r;
            b_r       <= b_r;
        end
    end

    assign vga.DrawX        = hc_r;
    assign vga.DrawY        = vc_r;
    assign vga.pixel_en     = pixel_en_s;
    assign vga.frame_start  = frame_start_s;
    assign vga.vblank_start = vblank_start_s;
    assign vga.VGA_HS       = hs_r;
    assign vga.VGA_VS       = vs_r;
    assign vga.VGA_BLANK_N  = blank_n_r;
    assign vga.VGA_SYNC_N   = 1'b0;
    assign vga.VGA_R        = r_r;
    assign vga.VGA_G        = g_r;
    assign vga.VGA_B        = b_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster so several frames fit in a short run.
// The reference model tracks only the number of Clk edges since reset and derives
// everything else (pixel index, position, regions, expected VGA outputs) arithmetically.
module tb_vga_timing_gen;

    localparam int HV = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NCYC = 9000;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .vga   (vif.master)
    );

    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // model state
    int   k;
    logic m_hs, m_vs, m_bn;
    logic [7:0] m_r, m_g, m_b;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k    = 0;
        m_hs = 1'b1;
        m_vs = 1'b1;
        m_bn = 1'b0;
        m_r  = 8'd0;
        m_g  = 8'd0;
        m_b  = 8'd0;
    endtask

    initial begin
        int   mode;
        int   p, hx, vy;
        bit   pe;
        int   last_fs;
        int   hs_run, vs_run;
        bit   directed_done;

        mode          = 0;
        last_fs       = -1;
        hs_run        = 0;
        vs_run        = 0;
        directed_done = 1'b0;
        vif.Red   = 8'd0;
        vif.Green = 8'd0;
        vif.Blue  = 8'd0;
        Reset     = 1'b1;
        repeat (3) @(posedge Clk);
        model_reset();
        #1;

        for (int i = 0; i < NCYC; i++) begin
            p  = k / 2;
            hx = p % HT;
            vy = (p / HT) % VT;

            // choose inputs for this cycle
            if (i % 500 == 0) mode = $urandom_range(0, 2);
            Reset = 1'b0;
            if (i < 2) Reset = 1'b1;
            else if ($urandom_range(0, 1499) == 0) Reset = 1'b1;
            else if (!directed_done && i > 3000 && hx == HT - 10 && vy == VV / 2 + 2) begin
                Reset = 1'b1;
                directed_done = 1'b1;
            end
            case (mode)
                0: begin
                    vif.Red   = 8'($urandom);
                    vif.Green = 8'($urandom);
                    vif.Blue  = 8'($urandom);
                end
                1: begin
                    vif.Red   = 8'hFF;
                    vif.Green = 8'h55;
                    vif.Blue  = 8'h00;
                end
                default: begin
                    vif.Red   = vif.DrawX[7:0];
                    vif.Green = vif.DrawY[7:0];
                    vif.Blue  = 8'($urandom);
                end
            endcase
            #1;

            pe = (Reset == 1'b0) && (k % 2 == 1);
            check_val("DrawX", 32'(vif.DrawX), 32'(hx));
            check_val("DrawY", 32'(vif.DrawY), 32'(vy));
            check_val("pixel_en", 32'(vif.pixel_en), 32'(pe));
            check_val("frame_start", 32'(vif.frame_start), 32'(pe && hx == 0 && vy == 0));
            check_val("vblank_start", 32'(vif.vblank_start), 32'(pe && hx == 0 && vy == VV));
            check_val("VGA_HS", 32'(vif.VGA_HS), 32'(m_hs));
            check_val("VGA_VS", 32'(vif.VGA_VS), 32'(m_vs));
            check_val("VGA_BLANK_N", 32'(vif.VGA_BLANK_N), 32'(m_bn));
            check_val("VGA_SYNC_N", 32'(vif.VGA_SYNC_N), 32'd0);
            check_val("VGA_RGB", {8'd0, vif.VGA_R, vif.VGA_G, vif.VGA_B}, {8'd0, m_r, m_g, m_b});

            // frame period and sync pulse widths measured from observed outputs
            if (vif.frame_start === 1'b1) begin
                if (last_fs >= 0) check_val("fs_period", 32'(i - last_fs), 32'(2 * HT * VT));
                last_fs = i;
            end
            if (vif.VGA_HS === 1'b0) hs_run++;
            else begin
                if (hs_run > 0) check_val("hs_width", 32'(hs_run), 32'(2 * HS));
                hs_run = 0;
            end
            if (vif.VGA_VS === 1'b0) vs_run++;
            else begin
                if (vs_run > 0) check_val("vs_width", 32'(vs_run), 32'(2 * VS * HT));
                vs_run = 0;
            end
            if (Reset) begin
                last_fs = -1;
                hs_run  = 0;
                vs_run  = 0;
            end

            @(posedge Clk);
            if (Reset) begin
                model_reset();
            end else begin
                if (k % 2 == 1) begin
                    m_hs = !(hx >= HV + HF && hx < HV + HF + HS);
                    m_vs = !(vy >= VV + VF && vy < VV + VF + VS);
                    m_bn = (hx < HV) && (vy < VV);
                    m_r  = m_bn ? vif.Red   : 8'd0;
                    m_g  = m_bn ? vif.Green : 8'd0;
                    m_b  = m_bn ? vif.Blue  : 8'd0;
                end
                k++;
            end
            #1;
        end

        check_val("directed_reset_hit", 32'(directed_done), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
